// File: rtl/maf_pipe_sched.sv
// rtl/maf_pipe_sched.sv - round-robin multi-pass issue scheduler and stage tracker for the MAF pipeline
// Grants one of NREQ requesters, issues its op as P passes into T1, and tracks tags down to T4.
module maf_pipe_sched #(
  parameter int NREQ   = 3,
  parameter int STAGES = 5,
  parameter int CW     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*CW-1:0]   i_req_passes,
  input  logic                 i_out_ready,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy,
  output logic                 o_issue_vld,
  output logic                 o_S_A,
  output logic                 o_S_B,
  output logic                 o_S_C,
  output logic                 o_S_A_H,
  output logic                 o_S_B_H,
  output logic                 o_S_C_H,
  output logic [CW-1:0]        o_cont,
  output logic                 o_issue_last,
  output logic [STAGES-1:0]    o_stage_en,
  output logic [STAGES-1:0]    o_stage_vld,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [1:0]           o_done_id
);

  localparam int IDW = 2;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic [CW-1:0]      r_p;
  logic [CW-1:0]      r_cont_cnt;
  logic [STAGES-1:0]  r_vld;
  logic [STAGES-1:0]  r_tlast;
  logic [IDW-1:0]     r_tid [STAGES];

  logic               w_stall;
  logic               w_issue;
  logic               w_last;
  logic               w_do_grant;
  logic               w_win_vld;
  logic [IDW-1:0]     w_win;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_cand;
  logic [CW-1:0]      w_req_p;
  logic [NREQ-1:0]    w_src;

  assign w_stall    = r_vld[STAGES-1] & ~i_out_ready;
  assign w_issue    = (r_state == ISSUE) & ~w_stall;
  assign w_last     = (r_cont_cnt == r_p - CW'(1));
  assign w_do_grant = (r_state == IDLE) & ~w_stall & w_win_vld;

  // Search downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      w_cand = w_sum[IDW-1:0];
      if (i_req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win     = w_cand;
      end
    end
  end

  always_comb begin
    w_req_p = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_req_p = i_req_passes[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_p        <= CW'(1);
      r_cont_cnt <= '0;
      r_vld      <= '0;
      r_tlast    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_tid[k] <= '0;
      end
    end else begin
      if (!w_stall) begin
        r_vld    <= {r_vld[STAGES-2:0], w_issue};
        r_tlast  <= {r_tlast[STAGES-2:0], w_issue & w_last};
        r_tid[0] <= r_id;
        for (int k = 1; k < STAGES; k++) begin
          r_tid[k] <= r_tid[k-1];
        end
      end
      case (r_state)
        IDLE: begin
          if (w_do_grant) begin
            r_id       <= w_win;
            r_p        <= (w_req_p == '0) ? CW'(1) : w_req_p;
            r_rr_ptr   <= (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
            r_cont_cnt <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!w_stall) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_cont_cnt <= r_cont_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_src        = w_issue ? (NREQ'(1) << r_id) : '0;
  assign o_grant      = w_do_grant ? (NREQ'(1) << w_win) : '0;
  assign o_issue_vld  = w_issue;
  assign o_issue_last = w_issue & w_last;
  assign o_S_A        = w_src[0];
  assign o_S_B        = w_src[1];
  assign o_S_C        = w_src[2];
  assign o_S_A_H      = w_src[0] & o_issue_last;
  assign o_S_B_H      = w_src[1] & o_issue_last;
  assign o_S_C_H      = w_src[2] & o_issue_last;
  // cont stays visible while an issue is stalled so the pending pass index is observable.
  assign o_cont       = (r_state == ISSUE) ? r_cont_cnt : '0;
  assign o_stall      = w_stall;
  assign o_stage_en   = {STAGES{~w_stall}};
  assign o_stage_vld  = r_vld;
  assign o_busy       = (r_state == ISSUE) | (|r_vld);
  assign o_done       = r_vld[STAGES-1] & r_tlast[STAGES-1] & i_out_ready;
  assign o_done_id    = r_tid[STAGES-1];

endmodule

// File: tb/tb_maf_pipe_sched.sv
// tb/tb_maf_pipe_sched.sv - self-checking bench for maf_pipe_sched
module tb_maf_pipe_sched;

  localparam int NREQ   = 3;
  localparam int STAGES = 5;
  localparam int CW     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  req_passes;
  logic        out_ready;
  logic [2:0]  o_grant;
  logic        o_busy, o_issue_vld, o_issue_last, o_stall, o_done;
  logic        o_S_A, o_S_B, o_S_C, o_S_A_H, o_S_B_H, o_S_C_H;
  logic [2:0]  o_cont;
  logic [4:0]  o_stage_en, o_stage_vld;
  logic [1:0]  o_done_id;

  maf_pipe_sched #(.NREQ(NREQ), .STAGES(STAGES), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_passes(req_passes),
    .i_out_ready(out_ready), .o_grant(o_grant), .o_busy(o_busy),
    .o_issue_vld(o_issue_vld), .o_S_A(o_S_A), .o_S_B(o_S_B), .o_S_C(o_S_C),
    .o_S_A_H(o_S_A_H), .o_S_B_H(o_S_B_H), .o_S_C_H(o_S_C_H), .o_cont(o_cont),
    .o_issue_last(o_issue_last), .o_stage_en(o_stage_en), .o_stage_vld(o_stage_vld),
    .o_stall(o_stall), .o_done(o_done), .o_done_id(o_done_id)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_passes = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [10:0] ivec_exp(bit iss, int cont, bit last, logic [2:0] src);
    if (!iss) return 11'b0;
    return {1'b1, 3'(cont), last, src, last ? src : 3'b000};
  endfunction

  function automatic logic [10:0] ivec_act(bit show_cont);
    return {o_issue_vld, show_cont ? o_cont : 3'b000, o_issue_last,
            o_S_C, o_S_B, o_S_A, o_S_C_H, o_S_B_H, o_S_A_H};
  endfunction

  typedef struct {
    logic [2:0] req;
    logic [8:0] passes;
    logic [2:0] exp_grant;
    int         exp_id;
    int         exp_p;
  } vec_t;

  typedef struct {
    int id;
    bit last;
    int age;
  } pass_t;

  vec_t  vecs[6];
  pass_t pq[$];

  int         rr, mid, mp, mk, win;
  bit         act, head_end, stall_e, issue_e, last_e, done_e, saw_done;
  logic [2:0] preq, grant_e, src_e;
  logic [8:0] ppass;
  logic [4:0] vmask;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // {req, passes {C,B,A}, expected grant, expected id, expected passes}
    vecs[0] = '{3'b001, {3'd0, 3'd0, 3'd3}, 3'b001, 0, 3};
    vecs[1] = '{3'b010, {3'd0, 3'd0, 3'd0}, 3'b010, 1, 1};
    vecs[2] = '{3'b011, {3'd0, 3'd2, 3'd7}, 3'b001, 0, 7};
    vecs[3] = '{3'b101, {3'd4, 3'd0, 3'd1}, 3'b100, 2, 4};
    vecs[4] = '{3'b110, {3'd1, 3'd5, 3'd0}, 3'b010, 1, 5};
    vecs[5] = '{3'b010, {3'd0, 3'd2, 3'd0}, 3'b010, 1, 2};

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_grant", int'(o_grant), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_stage_vld", int'(o_stage_vld), 0);
    chk("rst_stage_en", int'(o_stage_en), 5'h1f);
    chk("rst_issue", int'(ivec_act(1'b1)), 0);
    chk("rst_done", int'(o_done), 0);

    // single ops from an idle pipeline: grant, pass sequence, done latency
    for (int i = 0; i < 6; i++) begin
      tick();
      req = vecs[i].req; req_passes = vecs[i].passes;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), int'(o_grant), int'(vecs[i].exp_grant));
      tick();
      req = '0;
      for (int p = 0; p < vecs[i].exp_p; p++) begin
        if (p > 0) tick();
        @(negedge clk);
        chk($sformatf("vec%0d_issue%0d", i, p), int'(ivec_act(1'b1)),
            int'(ivec_exp(1'b1, p, p == vecs[i].exp_p - 1, vecs[i].exp_grant)));
      end
      for (int d = 1; d <= 5; d++) begin
        tick();
        @(negedge clk);
        if (d == 4) chk($sformatf("vec%0d_done_early", i), int'(o_done), 0);
        if (d == 5) begin
          chk($sformatf("vec%0d_done", i), int'(o_done), 1);
          chk($sformatf("vec%0d_done_id", i), int'(o_done_id), vecs[i].exp_id);
        end
      end
    end

    // round robin with all requests held: A, B, C, A two cycles apart
    do_reset();
    req = 3'b111; req_passes = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk($sformatf("rr_grant_c%0d", c), int'(o_grant), (c % 2 == 0) ? (1 << ((c / 2) % 3)) : 0);
    end
    tick();
    req = '0;
    for (int c = 0; c < 10; c++) tick();

    // output back-pressure while A (7 passes) is still issuing
    do_reset();
    req = 3'b001; req_passes = {3'd0, 3'd0, 3'd7};
    @(negedge clk);
    chk("stall_grant", int'(o_grant), 1);
    tick();
    req = '0;
    for (int c = 2; c <= 5; c++) tick();
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      @(negedge clk);
      chk($sformatf("stall_s%0d", s), int'(o_stall), 1);
      chk($sformatf("stall_en_s%0d", s), int'(o_stage_en), 0);
      chk($sformatf("stall_vld_s%0d", s), int'(o_stage_vld), 5'h1f);
      chk($sformatf("stall_issue_s%0d", s), int'(o_issue_vld), 0);
      chk($sformatf("stall_cont_s%0d", s), int'(o_cont), 5);
      chk($sformatf("stall_done_s%0d", s), int'(o_done), 0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_issue5", int'(ivec_act(1'b1)), int'(ivec_exp(1'b1, 5, 1'b0, 3'b001)));
    chk("resume_drop_no_done", int'(o_done), 0);
    tick();
    @(negedge clk);
    chk("resume_issue6", int'(ivec_act(1'b1)), int'(ivec_exp(1'b1, 6, 1'b1, 3'b001)));
    for (int c = 11; c <= 14; c++) tick();
    @(negedge clk);
    chk("stall_done_not_yet", int'(o_done), 0);
    tick();
    @(negedge clk);
    chk("stall_done_delayed", int'(o_done), 1);
    chk("stall_done_id", int'(o_done_id), 0);
    tick();
    @(negedge clk);
    chk("stall_drained", int'(o_busy), 0);

    // reset in the middle of a 4-pass B op
    do_reset();
    req = 3'b010; req_passes = {3'd0, 3'd4, 3'd0};
    @(negedge clk);
    chk("mid_rst_grant", int'(o_grant), 3'b010);
    tick();
    req = '0;
    tick();
    @(negedge clk);
    chk("mid_rst_cont1", int'(ivec_act(1'b1)), int'(ivec_exp(1'b1, 1, 1'b0, 3'b010)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", int'(o_stage_vld), 0);
    chk("mid_rst_issue", int'(o_issue_vld), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", int'(saw_done), 0);
    tick();
    req = 3'b110; req_passes = '0;
    @(negedge clk);
    chk("mid_rst_rr_ptr", int'(o_grant), 3'b010);
    tick();
    req = '0;
    for (int c = 0; c < 10; c++) tick();

    // randomized traffic against a transaction-level reference model
    do_reset();
    rr = 0; act = 1'b0; mid = 0; mp = 1; mk = 0;
    preq = '0; ppass = '0; pq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (!preq[r] && $urandom_range(0, 2) == 0) begin
          preq[r] = 1'b1;
          ppass[r*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
      req = preq; req_passes = ppass;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);

      head_end = (pq.size() > 0) && (pq[0].age == STAGES - 1);
      stall_e  = head_end && !out_ready;
      win = -1;
      if (!act && !stall_e) begin
        for (int k = 0; k < 3; k++) begin
          if (win < 0 && preq[(rr + k) % 3]) win = (rr + k) % 3;
        end
      end
      grant_e = (win >= 0) ? 3'(1 << win) : 3'b000;
      issue_e = act && !stall_e;
      last_e  = (mk == mp - 1);
      src_e   = 3'(1 << mid);
      vmask   = '0;
      for (int j = 0; j < pq.size(); j++) vmask = vmask | 5'(1 << pq[j].age);
      done_e  = head_end && pq[0].last && out_ready;

      chk("rnd_grant", int'(o_grant), int'(grant_e));
      chk("rnd_issue", int'(ivec_act(issue_e)), int'(ivec_exp(issue_e, mk, last_e, src_e)));
      chk("rnd_stall", int'(o_stall), int'(stall_e));
      chk("rnd_stage_en", int'(o_stage_en), stall_e ? 0 : 5'h1f);
      chk("rnd_stage_vld", int'(o_stage_vld), int'(vmask));
      chk("rnd_busy", int'(o_busy), int'(act || pq.size() > 0));
      chk("rnd_done", int'(o_done), int'(done_e));
      if (done_e) chk("rnd_done_id", int'(o_done_id), pq[0].id);

      if (!stall_e) begin
        for (int j = 0; j < pq.size(); j++) pq[j].age++;
        if (pq.size() > 0 && pq[0].age == STAGES) void'(pq.pop_front());
        if (issue_e) pq.push_back('{mid, last_e, 0});
      end
      if (issue_e) begin
        if (last_e) act = 1'b0;
        else mk++;
      end
      if (win >= 0) begin
        act = 1'b1;
        mid = win;
        mp  = (ppass[win*3 +: 3] == 3'd0) ? 1 : int'(ppass[win*3 +: 3]);
        mk  = 0;
        rr  = (win + 1) % 3;
        preq[win] = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
